// File: rtl/iob_soc_versat_l2_arbiter_pkg.sv
// iob_soc_versat_l2_arbiter_pkg: shared FSM state encoding for the L2 front-end arbiter
package iob_soc_versat_l2_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        INVAL  = 2'd3
    } state_t;
endpackage

// File: rtl/iob_soc_versat_l2_arbiter_rr_pick.sv
// iob_soc_versat_rr_pick: combinational round-robin pick, first request after last
module iob_soc_versat_rr_pick #(
    parameter int N  = 2,
    parameter int GW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last,
    output logic [GW-1:0] pick,
    output logic          any
);
    logic [GW-1:0] idx;
    // scan farthest-first so the nearest requester after last overwrites
    always_comb begin
        pick = '0;
        idx  = '0;
        any  = |req;
        for (int i = N; i >= 1; i--) begin
            idx = GW'((int'(last) + i) % N);
            if (req[idx]) pick = idx;
        end
    end
endmodule

// File: rtl/iob_soc_versat_l2_arbiter.sv
// iob_soc_versat_l2_arbiter: round-robin sharing of the L2 IOb front-end
// between cache back-ends, one outstanding transaction, gated invalidation
module iob_soc_versat_l2_arbiter
    import iob_soc_versat_l2_arbiter_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 22,
    parameter int DATA_W    = 32
) (
    input  logic                           clk_i,
    input  logic                           cke_i,
    input  logic                           arst_n_i,
    input  logic [N_MASTERS-1:0]           m_valid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]    m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]    m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0]  m_wstrb_i,
    output logic [N_MASTERS-1:0]           m_ready_o,
    output logic [N_MASTERS-1:0]           m_rvalid_o,
    output logic [DATA_W-1:0]              m_rdata_o,
    output logic                           s_valid_o,
    output logic [ADDR_W-1:0]              s_addr_o,
    output logic [DATA_W-1:0]              s_wdata_o,
    output logic [DATA_W/8-1:0]            s_wstrb_o,
    input  logic                           s_ready_i,
    input  logic                           s_rvalid_i,
    input  logic [DATA_W-1:0]              s_rdata_i,
    input  logic                           inv_req_i,
    input  logic                           s_wtb_empty_i,
    output logic                           s_invalidate_o,
    output logic                           inv_busy_o,
    output logic [$clog2(N_MASTERS)-1:0]   grant_o
);
    localparam int GW = $clog2(N_MASTERS);
    localparam int SW = DATA_W / 8;

    state_t        state, state_n;
    logic [GW-1:0] grant, grant_n, last_grant, last_grant_n, pick;
    logic          pending, pending_n, any_req;
    logic [SW-1:0] wstrb_g;

    iob_soc_versat_rr_pick #(.N(N_MASTERS), .GW(GW)) u_pick (
        .req (m_valid_i),
        .last(last_grant),
        .pick(pick),
        .any (any_req)
    );

    assign wstrb_g    = m_wstrb_i[int'(grant)*SW +: SW];
    assign pending_n  = inv_req_i | (pending & ~s_invalidate_o);
    assign inv_busy_o = pending | (state == INVAL);
    assign grant_o    = grant;

    always_comb begin
        state_n        = state;
        grant_n        = grant;
        last_grant_n   = last_grant;
        s_valid_o      = 1'b0;
        s_addr_o       = '0;
        s_wdata_o      = '0;
        s_wstrb_o      = '0;
        m_ready_o      = '0;
        m_rvalid_o     = '0;
        m_rdata_o      = '0;
        s_invalidate_o = 1'b0;
        case (state)
            IDLE: begin
                // a same-cycle inv_req_i already beats a new grant
                if (pending | inv_req_i) state_n = INVAL;
                else if (any_req) begin
                    state_n      = REQ;
                    grant_n      = pick;
                    last_grant_n = pick;
                end
            end
            REQ: begin
                s_valid_o        = m_valid_i[grant];
                s_addr_o         = m_addr_i[int'(grant)*ADDR_W +: ADDR_W];
                s_wdata_o        = m_wdata_i[int'(grant)*DATA_W +: DATA_W];
                s_wstrb_o        = wstrb_g;
                m_ready_o[grant] = s_ready_i;
                if (s_ready_i) state_n = (|wstrb_g) ? IDLE : WAIT_R;
            end
            WAIT_R: begin
                if (s_rvalid_i) begin
                    m_rvalid_o[grant] = 1'b1;
                    m_rdata_o         = s_rdata_i;
                    state_n           = IDLE;
                end
            end
            INVAL: begin
                if (s_wtb_empty_i) begin
                    s_invalidate_o = 1'b1;
                    state_n        = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(N_MASTERS - 1);
            pending    <= 1'b0;
        end else if (cke_i) begin
            state      <= state_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            pending    <= pending_n;
        end
    end

    a_hold_valid: assert property (@(posedge clk_i) disable iff (!arst_n_i)
        (state == REQ) |-> m_valid_i[grant]);
endmodule
